// File: rtl/ram_multiport.sv
// ram_multiport: single-clock data RAM with one byte-maskable write port and READ_PORTS
// independent synchronous read ports (1- or 2-edge registered read latency). A clear
// sequencer zero-fills the array after reset and whenever Clear is pulsed.
//
// Optional feature: define RAM_WRITE_BYPASS_EN for write-first read-during-write
// (enabled lanes forwarded from DATA_WRITE); default build is read-first.
//
// Ports:
//   Clock, Reset         rising-edge clock, asynchronous active-high reset
//   Clear                one-cycle pulse restarting the zero-fill sweep
//   Ready                1 = array usable, 0 = clearing
//   write_address, Write_Enable, Byte_Enable, DATA_WRITE   write port
//   read_address, Read_Enable                              read requests, port p at slice p
//   DATA_READ, Read_Valid                                  read results, port p at slice p
module ram_multiport #(
  parameter int unsigned DATA_WIDTH    = 16,
  parameter int unsigned ADDRESS_WIDTH = 4,
  parameter int unsigned BYTE_WIDTH    = 8,
  parameter int unsigned READ_PORTS    = 2,
  parameter int unsigned READ_LATENCY  = 1
) (
  input  logic                                Clock,
  input  logic                                Reset,
  input  logic                                Clear,
  output logic                                Ready,
  input  logic [ADDRESS_WIDTH-1:0]            write_address,
  input  logic                                Write_Enable,
  input  logic [DATA_WIDTH/BYTE_WIDTH-1:0]    Byte_Enable,
  input  logic [DATA_WIDTH-1:0]               DATA_WRITE,
  input  logic [READ_PORTS*ADDRESS_WIDTH-1:0] read_address,
  input  logic [READ_PORTS-1:0]               Read_Enable,
  output logic [READ_PORTS*DATA_WIDTH-1:0]    DATA_READ,
  output logic [READ_PORTS-1:0]               Read_Valid
);

  localparam int unsigned DEPTH = 1 << ADDRESS_WIDTH;
  localparam int unsigned LANES = DATA_WIDTH / BYTE_WIDTH;

  localparam logic StClear = 1'b0;
  localparam logic StReady = 1'b1;

  if (READ_LATENCY != 1 && READ_LATENCY != 2) begin : g_bad_latency
    $error("ram_multiport: READ_LATENCY must be 1 or 2");
  end
  if (DATA_WIDTH % BYTE_WIDTH != 0) begin : g_bad_lanes
    $error("ram_multiport: DATA_WIDTH must be a multiple of BYTE_WIDTH");
  end

  logic                     state_q, state_d;
  logic [ADDRESS_WIDTH-1:0] ptr_q, ptr_d;
  logic                     wr_acc;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  assign Ready  = (state_q == StReady);
  // Clear wins over a same-cycle write or read
  assign wr_acc = Ready && Write_Enable && !Clear;

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    case (state_q)
      StClear: begin
        ptr_d = ptr_q + 1'b1;
        if (ptr_q == ADDRESS_WIDTH'(DEPTH - 1)) state_d = StReady;
      end
      StReady: begin
        if (Clear) begin
          state_d = StClear;
          ptr_d   = '0;
        end
      end
      default: state_d = StClear;
    endcase
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state_q <= StClear;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
    end
  end

  // Array has no reset of its own; the sweep zeroes it.
  always_ff @(posedge Clock) begin
    if (state_q == StClear) begin
      mem[ptr_q] <= '0;
    end else if (wr_acc) begin
      for (int unsigned i = 0; i < LANES; i++) begin
        if (Byte_Enable[i]) mem[write_address][i*BYTE_WIDTH +: BYTE_WIDTH] <=
            DATA_WRITE[i*BYTE_WIDTH +: BYTE_WIDTH];
      end
    end
  end

  for (genvar p = 0; p < READ_PORTS; p++) begin : g_port
    logic [ADDRESS_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0]    word;
    logic                     acc;
    logic [DATA_WIDTH-1:0]    d1_q;
    logic                     v1_q;

    assign addr = read_address[p*ADDRESS_WIDTH +: ADDRESS_WIDTH];
    assign acc  = Ready && Read_Enable[p] && !Clear;

    always_comb begin
      word = mem[addr];
`ifdef RAM_WRITE_BYPASS_EN
      if (wr_acc && (write_address == addr)) begin
        for (int unsigned i = 0; i < LANES; i++) begin
          if (Byte_Enable[i]) word[i*BYTE_WIDTH +: BYTE_WIDTH] =
              DATA_WRITE[i*BYTE_WIDTH +: BYTE_WIDTH];
        end
      end
`endif
    end

    always_ff @(posedge Clock or posedge Reset) begin
      if (Reset) begin
        d1_q <= '0;
        v1_q <= 1'b0;
      end else begin
        v1_q <= acc;
        if (acc) d1_q <= word;
      end
    end

    if (READ_LATENCY == 2) begin : g_lat2
      logic [DATA_WIDTH-1:0] d2_q;
      logic                  v2_q;

      // Second stage ignores Clear so a sampled read always completes
      always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
          d2_q <= '0;
          v2_q <= 1'b0;
        end else begin
          v2_q <= v1_q;
          if (v1_q) d2_q <= d1_q;
        end
      end

      assign DATA_READ[p*DATA_WIDTH +: DATA_WIDTH] = d2_q;
      assign Read_Valid[p]                         = v2_q;
    end else begin : g_lat1
      assign DATA_READ[p*DATA_WIDTH +: DATA_WIDTH] = d1_q;
      assign Read_Valid[p]                         = v1_q;
    end
  end

endmodule

// File: tb/tb_ram_multiport.sv
// Directed bench for ram_multiport: one default-latency instance and one READ_LATENCY=2
// instance sharing clock, write bus and Clear, with separate resets and read ports.
module tb_ram_multiport;

  logic        clk;
  logic        rst, rst2;
  logic        clr;
  logic        rdy, rdy2;
  logic [3:0]  waddr;
  logic        we;
  logic [1:0]  be;
  logic [15:0] wdata;
  logic [7:0]  raddr, raddr2;
  logic [1:0]  re, re2;
  logic [31:0] rdata, rdata2;
  logic [1:0]  rvalid, rvalid2;

  int n_cmp = 0;
  int n_err = 0;
  int n;

  ram_multiport dut (
    .Clock         (clk),
    .Reset         (rst),
    .Clear         (clr),
    .Ready         (rdy),
    .write_address (waddr),
    .Write_Enable  (we),
    .Byte_Enable   (be),
    .DATA_WRITE    (wdata),
    .read_address  (raddr),
    .Read_Enable   (re),
    .DATA_READ     (rdata),
    .Read_Valid    (rvalid)
  );

  ram_multiport #(.READ_LATENCY(2)) dut2 (
    .Clock         (clk),
    .Reset         (rst2),
    .Clear         (clr),
    .Ready         (rdy2),
    .write_address (waddr),
    .Write_Enable  (we),
    .Byte_Enable   (be),
    .DATA_WRITE    (wdata),
    .read_address  (raddr2),
    .Read_Enable   (re2),
    .DATA_READ     (rdata2),
    .Read_Valid    (rvalid2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    rst = 1'b1; rst2 = 1'b1; clr = 1'b0;
    waddr = '0; we = 1'b0; be = '0; wdata = '0;
    raddr = '0; re = '0; raddr2 = '0; re2 = '0;
    step; step;
    chk("rst_ready", 32'(rdy), 32'd0);
    chk("rst_data", rdata, 32'h0);
    chk("rst_valid", 32'(rvalid), 32'd0);
    chk("rst_valid_l2", 32'(rvalid2), 32'd0);

    // 1: sweep length, then read a zeroed word
    rst = 1'b0; rst2 = 1'b0;
    n = 0;
    for (int i = 1; i <= 40; i++) begin
      step;
      if (rdy) begin
        n = i;
        break;
      end
    end
    chk("ready_edges", 32'(n), 32'd16);
    raddr = 8'h09; re = 2'b01;
    step;
    re = 2'b00;
    chk("t1_data", 32'(rdata[15:0]), 32'h0000);
    chk("t1_valid", 32'(rvalid), 32'd1);
    step;
    chk("t1_pulse", 32'(rvalid), 32'd0);

    // 2: byte-masked overwrite
    we = 1'b1; waddr = 4'h9; wdata = 16'hC5A3; be = 2'b11;
    step;
    wdata = 16'hFF11; be = 2'b01;
    step;
    we = 1'b0; raddr = 8'h09; re = 2'b01;
    step;
    re = 2'b00;
    chk("t2_data", 32'(rdata[15:0]), 32'hC511);
    chk("t2_valid", 32'(rvalid), 32'd1);

    // 3: both ports in the same cycle, then hold
    we = 1'b1; waddr = 4'hF; wdata = 16'h0009; be = 2'b11;
    step;
    waddr = 4'h1; wdata = 16'h000F;
    step;
    we = 1'b0; raddr = 8'h1F; re = 2'b11;
    step;
    re = 2'b00;
    chk("t3_data", rdata, 32'h000F_0009);
    chk("t3_valid", 32'(rvalid), 32'd3);
    step;
    chk("t3_hold_data", rdata, 32'h000F_0009);
    chk("t3_hold_valid", 32'(rvalid), 32'd0);

    // 4: read during write to the same address
    we = 1'b1; waddr = 4'h1; wdata = 16'h1234; be = 2'b11; raddr = 8'h01; re = 2'b01;
    step;
    we = 1'b0; re = 2'b00;
`ifdef RAM_WRITE_BYPASS_EN
    chk("t4_rdw", 32'(rdata[15:0]), 32'h1234);
`else
    chk("t4_rdw", 32'(rdata[15:0]), 32'h000F);
`endif
    // Byte_Enable=0 write is a no-op
    we = 1'b1; wdata = 16'hFFFF; be = 2'b00;
    step;
    we = 1'b0; re = 2'b01;
    step;
    re = 2'b00;
    chk("t4_after", 32'(rdata[15:0]), 32'h1234);

    // 5: Clear beats a same-cycle read; sweep ignores traffic
    clr = 1'b1; raddr = 8'h09; re = 2'b01;
    step;
    clr = 1'b0; re = 2'b00;
    chk("t5_ready_low", 32'(rdy), 32'd0);
    chk("t5_clr_read", 32'(rvalid), 32'd0);
    n = 0;
    for (int i = 1; i <= 40; i++) begin
      if (i == 3) begin
        we = 1'b1; waddr = 4'h9; wdata = 16'hBEEF; be = 2'b11; re = 2'b01;
      end
      step;
      if (i == 3) begin
        chk("t5_read_ignored", 32'(rvalid), 32'd0);
        we = 1'b0; re = 2'b00;
      end
      if (rdy) begin
        n = i;
        break;
      end
    end
    chk("t5_clear_edges", 32'(n), 32'd16);
    re = 2'b01;
    step;
    re = 2'b00;
    chk("t5_data", 32'(rdata[15:0]), 32'h0000);
    chk("t5_valid", 32'(rvalid), 32'd1);

    // 6: two-edge latency, then reset with a read in flight
    we = 1'b1; waddr = 4'h3; wdata = 16'hA55A; be = 2'b11;
    step;
    we = 1'b0; raddr2 = 8'h03; re2 = 2'b01;
    step;
    re2 = 2'b00;
    chk("t6_l2_early", 32'(rvalid2), 32'd0);
    step;
    chk("t6_l2_valid", 32'(rvalid2), 32'd1);
    chk("t6_l2_data", 32'(rdata2[15:0]), 32'hA55A);
    step;
    chk("t6_l2_pulse", 32'(rvalid2), 32'd0);
    re2 = 2'b01;
    step;
    re2 = 2'b00;
    #2 rst2 = 1'b1;
    #1;
    chk("t6_rst_valid", 32'(rvalid2), 32'd0);
    chk("t6_rst_data", rdata2, 32'h0);
    chk("t6_rst_ready", 32'(rdy2), 32'd0);
    #2 rst2 = 1'b0;
    step;
    chk("t6_no_pulse1", 32'(rvalid2), 32'd0);
    step;
    chk("t6_no_pulse2", 32'(rvalid2), 32'd0);
    chk("t6_other_ready", 32'(rdy), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
